// File: rtl/cpu_6502_pkg.sv
// Shared types for the cpu_6502 core: FSM states, ALU operations, opcodes
// and the debug snapshot struct exported by the top.
package cpu_6502_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_ABS1   = 3'd3,
      S_ABS2   = 3'd4,
      S_READ   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      ALU_PASS = 2'd0,
      ALU_ADC  = 2'd1,
      ALU_INC  = 2'd2
   } alu_op_t;

   localparam logic [7:0] OP_LDA_IMM = 8'hA9;
   localparam logic [7:0] OP_LDX_IMM = 8'hA2;
   localparam logic [7:0] OP_LDY_IMM = 8'hA0;
   localparam logic [7:0] OP_ADC_IMM = 8'h69;
   localparam logic [7:0] OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_STA_ABS = 8'h8D;
   localparam logic [7:0] OP_JMP_ABS = 8'h4C;
   localparam logic [7:0] OP_TAX     = 8'hAA;
   localparam logic [7:0] OP_TXA     = 8'h8A;
   localparam logic [7:0] OP_INX     = 8'hE8;
   localparam logic [7:0] OP_CLC     = 8'h18;
   localparam logic [7:0] OP_SEC     = 8'h38;
   localparam logic [7:0] OP_NOP     = 8'hEA;

   // Architectural snapshot so checkers can observe the core without probing internals.
   typedef struct packed {
      state_t      state;
      logic [15:0] pc;
      logic [7:0]  a;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [7:0]  ir;
      logic [7:0]  lo;
      logic        n;
      logic        z;
      logic        c;
   } dbg_t;

endpackage

// File: rtl/cpu_6502_alu.sv
// Combinational ALU: add-with-carry, increment, and pass-through of b
// (loads and register transfers). N/Z always reflect the result.
module cpu_6502_alu
   import cpu_6502_pkg::*;
(
   input  alu_op_t    op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       carry_in,
   output logic [7:0] result,
   output logic       n,
   output logic       z,
   output logic       c
);

   logic [8:0] sum;

   always_comb begin
      sum    = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
      result = b;
      c      = carry_in;
      case (op)
         ALU_ADC: begin
            result = sum[7:0];
            c      = sum[8];
         end
         ALU_INC: result = b + 8'd1;
         default: result = b;
      endcase
      n = result[7];
      z = (result == 8'd0);
   end

endmodule

// File: rtl/cpu_6502.sv
// Reduced 6502-style core. The write-data port is named dout because "do"
// is a reserved word; positional order matches existing instances.
module cpu_6502
   import cpu_6502_pkg::*;
(
   input  logic [7:0]  di,
   output logic [7:0]  dout,
   input  logic        clk,
   input  logic        reset,
   output logic        we,
   output logic [15:0] ab,
   output dbg_t        dbg
);

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  a_q, a_d, x_q, x_d, y_q, y_d, ir_q, ir_d, lo_q, lo_d;
   logic        n_q, n_d, z_q, z_d, c_q, c_d;

   alu_op_t     alu_op;
   logic [7:0]  alu_b, alu_res;
   logic        alu_n, alu_z, alu_c;

   cpu_6502_alu u_alu (
      .op       (alu_op),
      .a        (a_q),
      .b        (alu_b),
      .carry_in (c_q),
      .result   (alu_res),
      .n        (alu_n),
      .z        (alu_z),
      .c        (alu_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= 16'h0000;
         a_q     <= 8'h00;
         x_q     <= 8'h00;
         y_q     <= 8'h00;
         ir_q    <= 8'h00;
         lo_q    <= 8'h00;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         x_q     <= x_d;
         y_q     <= y_d;
         ir_q    <= ir_d;
         lo_q    <= lo_d;
         n_q     <= n_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      x_d     = x_q;
      y_d     = y_q;
      ir_d    = ir_q;
      lo_d    = lo_q;
      n_d     = n_q;
      z_d     = z_q;
      c_d     = c_q;
      alu_op  = ALU_PASS;
      alu_b   = di;
      ab      = pc_q;
      dout    = 8'h00;
      we      = 1'b0;

      case (state_q)
         S_FETCH: begin
            pc_d    = pc_q + 16'd1;
            state_d = S_DECODE;
         end
         // Opcode arrives on di here; implied ops complete without touching PC.
         S_DECODE: begin
            ir_d    = di;
            state_d = S_FETCH;
            case (di)
               OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM: begin
                  pc_d    = pc_q + 16'd1;
                  state_d = S_EXEC;
               end
               OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: begin
                  pc_d    = pc_q + 16'd1;
                  state_d = S_ABS1;
               end
               OP_TAX: begin
                  alu_b = a_q;
                  x_d   = alu_res;
                  n_d   = alu_n;
                  z_d   = alu_z;
               end
               OP_TXA: begin
                  alu_b = x_q;
                  a_d   = alu_res;
                  n_d   = alu_n;
                  z_d   = alu_z;
               end
               OP_INX: begin
                  alu_op = ALU_INC;
                  alu_b  = x_q;
                  x_d    = alu_res;
                  n_d    = alu_n;
                  z_d    = alu_z;
               end
               OP_CLC:  c_d = 1'b0;
               OP_SEC:  c_d = 1'b1;
               default: ;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (ir_q)
               OP_LDA_IMM: begin a_d = alu_res; n_d = alu_n; z_d = alu_z; end
               OP_LDX_IMM: begin x_d = alu_res; n_d = alu_n; z_d = alu_z; end
               OP_LDY_IMM: begin y_d = alu_res; n_d = alu_n; z_d = alu_z; end
               OP_ADC_IMM: begin
                  alu_op = ALU_ADC;
                  a_d    = alu_res;
                  n_d    = alu_n;
                  z_d    = alu_z;
                  c_d    = alu_c;
               end
               default: ;
            endcase
         end
         S_ABS1: begin
            lo_d    = di;
            pc_d    = pc_q + 16'd1;
            state_d = S_ABS2;
         end
         // High address byte is only on di this cycle, so ab is driven straight from it.
         S_ABS2: begin
            state_d = S_FETCH;
            case (ir_q)
               OP_JMP_ABS: pc_d = {di, lo_q};
               OP_STA_ABS: begin
                  ab   = {di, lo_q};
                  dout = a_q;
                  we   = 1'b1;
               end
               OP_LDA_ABS: begin
                  ab      = {di, lo_q};
                  state_d = S_READ;
               end
               default: ;
            endcase
         end
         S_READ: begin
            a_d     = alu_res;
            n_d     = alu_n;
            z_d     = alu_z;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         ab   = 16'h0000;
         dout = 8'h00;
         we   = 1'b0;
      end
   end

   assign dbg = '{state: state_q, pc: pc_q, a: a_q, x: x_q, y: y_q,
                  ir: ir_q, lo: lo_q, n: n_q, z: z_q, c: c_q};

endmodule

// File: tb/tb_cpu_6502.sv
// Bench for cpu_6502: synchronous memory model, expected address/write
// queues consumed every cycle, register checks through the debug struct.
module tb_cpu_6502;
   import cpu_6502_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  di = 8'h00;
   logic [7:0]  dout;
   logic        we;
   logic [15:0] ab;
   dbg_t        dbg;

   logic [7:0]  mem [0:65535];
   logic [15:0] exp_ab_q[$];
   logic [23:0] exp_wr_q[$];
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   cpu_6502 dut (
      .di    (di),
      .dout  (dout),
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .ab    (ab),
      .dbg   (dbg)
   );

   // Synchronous memory: read data lands one cycle after the address.
   always @(posedge clk) begin
      di <= mem[ab];
      if (we) mem[ab] = dout;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic monitor();
      if (exp_ab_q.size() != 0) check("ab", ab, exp_ab_q.pop_front());
      if (we) begin
         if (exp_wr_q.size() == 0) check("we_unexpected", we, 0);
         else check("write", {ab, dout}, exp_wr_q.pop_front());
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         #1;
         monitor();
         @(negedge clk);
      end
   endtask

   task automatic push_ab(input logic [15:0] a);
      exp_ab_q.push_back(a);
   endtask

   task automatic begin_test();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
   endtask

   task automatic go();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic end_test(input string tag);
      check(tag, exp_ab_q.size(), 0);
      check(tag, exp_wr_q.size(), 0);
      exp_ab_q.delete();
      exp_wr_q.delete();
   endtask

   logic [7:0] a0, b0;
   logic       cin;
   logic [8:0] sum;

   initial begin
      // LDA # followed by unknown opcodes; also reset state
      begin_test();
      #1;
      check("rst_ab", ab, 16'h0000);
      check("rst_we", we, 0);
      check("rst_dout", dout, 0);
      check("rst_state", dbg.state, S_FETCH);
      check("rst_pc", dbg.pc, 0);
      mem[0] = 8'hA9; mem[1] = 8'h14;
      for (int i = 2; i < 16; i++) mem[i] = 8'h03;
      go();
      push_ab(16'h0); push_ab(16'h1); push_ab(16'h2); push_ab(16'h2);
      push_ab(16'h3); push_ab(16'h3); push_ab(16'h4);
      cycles(2);
      check("lda_a_early", dbg.a, 8'h00);
      cycles(1);
      check("lda_a", dbg.a, 8'h14);
      cycles(4);
      check("lda_n", dbg.n, 0);
      check("lda_z", dbg.z, 0);
      end_test("t1_left");

      // LDA #0, STA abs, LDY #
      begin_test();
      mem[0] = 8'hA9; mem[1] = 8'h00; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'h02;
      mem[5] = 8'hA0; mem[6] = 8'h80; mem[16'h0200] = 8'h55;
      go();
      push_ab(16'h0); push_ab(16'h1); push_ab(16'h2); push_ab(16'h2); push_ab(16'h3);
      push_ab(16'h4); push_ab(16'h0200); push_ab(16'h5); push_ab(16'h6); push_ab(16'h7);
      exp_wr_q.push_back({16'h0200, 8'h00});
      cycles(7);
      check("sta_z", dbg.z, 1);
      check("sta_mem", mem[16'h0200], 8'h00);
      cycles(3);
      check("ldy_y", dbg.y, 8'h80);
      check("ldy_n", dbg.n, 1);
      end_test("t2_left");

      // SEC, LDA #FF, ADC #01, ADC #10
      begin_test();
      mem[0] = 8'h38; mem[1] = 8'hA9; mem[2] = 8'hFF; mem[3] = 8'h69; mem[4] = 8'h01;
      mem[5] = 8'h69; mem[6] = 8'h10;
      go();
      cycles(8);
      check("adc1_a", dbg.a, 8'h01);
      check("adc1_c", dbg.c, 1);
      check("adc1_z", dbg.z, 0);
      cycles(3);
      check("adc2_a", dbg.a, 8'h12);
      check("adc2_c", dbg.c, 0);
      end_test("t3_left");

      // CLC, LDA #7F, ADC #01
      begin_test();
      mem[0] = 8'h18; mem[1] = 8'hA9; mem[2] = 8'h7F; mem[3] = 8'h69; mem[4] = 8'h01;
      go();
      cycles(8);
      check("adc3_a", dbg.a, 8'h80);
      check("adc3_n", dbg.n, 1);
      check("adc3_c", dbg.c, 0);
      end_test("t4_left");

      // JMP, LDX #FF, INX, TXA
      begin_test();
      mem[0] = 8'h4C; mem[1] = 8'h10; mem[2] = 8'h00;
      mem[16'h10] = 8'hA2; mem[16'h11] = 8'hFF; mem[16'h12] = 8'hE8; mem[16'h13] = 8'h8A;
      go();
      push_ab(16'h0); push_ab(16'h1); push_ab(16'h2); push_ab(16'h3);
      push_ab(16'h10); push_ab(16'h11); push_ab(16'h12); push_ab(16'h12);
      push_ab(16'h13); push_ab(16'h13); push_ab(16'h14);
      cycles(4);
      check("jmp_pc", dbg.pc, 16'h0010);
      cycles(3);
      check("ldx_x", dbg.x, 8'hFF);
      check("ldx_n", dbg.n, 1);
      cycles(2);
      check("inx_x", dbg.x, 8'h00);
      check("inx_z", dbg.z, 1);
      check("inx_n", dbg.n, 0);
      cycles(2);
      check("txa_a", dbg.a, 8'h00);
      check("txa_z", dbg.z, 1);
      check("txa_pc", dbg.pc, 16'h0014);
      end_test("t5_left");

      // LDA abs
      begin_test();
      mem[0] = 8'hAD; mem[1] = 8'h20; mem[2] = 8'h00; mem[16'h20] = 8'h85;
      go();
      push_ab(16'h0); push_ab(16'h1); push_ab(16'h2); push_ab(16'h20); push_ab(16'h3);
      push_ab(16'h3);
      cycles(4);
      check("ldaabs_a_early", dbg.a, 8'h00);
      check("ldaabs_lo", dbg.lo, 8'h20);
      cycles(1);
      check("ldaabs_a", dbg.a, 8'h85);
      check("ldaabs_n", dbg.n, 1);
      cycles(1);
      end_test("t6_left");

      // Reset during ABS2 of STA suppresses the write
      begin_test();
      mem[0] = 8'hA9; mem[1] = 8'h5A; mem[2] = 8'h8D; mem[3] = 8'h00; mem[4] = 8'h03;
      mem[16'h0300] = 8'h11;
      go();
      cycles(6);
      check("abort_a_pre", dbg.a, 8'h5A);
      check("abort_state_pre", dbg.state, S_ABS2);
      reset = 1'b1;
      #1;
      check("abort_we", we, 0);
      check("abort_ab", ab, 16'h0000);
      check("abort_dout", dout, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_mem", mem[16'h0300], 8'h11);
      check("abort_a", dbg.a, 8'h00);
      check("abort_pc", dbg.pc, 16'h0000);
      check("abort_state", dbg.state, S_FETCH);
      check("abort_ab_next", ab, 16'h0000);
      end_test("t7_left");

      // Random ADC with carry-in, result stored through the bus
      for (int k = 0; k < 6; k++) begin
         begin_test();
         a0  = 8'($urandom_range(0, 255));
         b0  = 8'($urandom_range(0, 255));
         cin = 1'($urandom_range(0, 1));
         if (k == 0) begin a0 = 8'hFF; b0 = 8'hFF; cin = 1'b1; end
         mem[0] = cin ? 8'h38 : 8'h18;
         mem[1] = 8'hA9; mem[2] = a0; mem[3] = 8'h69; mem[4] = b0;
         mem[5] = 8'h8D; mem[6] = 8'h00; mem[7] = 8'h04;
         sum = {1'b0, a0} + {1'b0, b0} + {8'd0, cin};
         exp_wr_q.push_back({16'h0400, sum[7:0]});
         go();
         cycles(13);
         check("rnd_c", dbg.c, sum[8]);
         check("rnd_n", dbg.n, sum[7]);
         check("rnd_z", dbg.z, (sum[7:0] == 8'h00));
         end_test("rnd_left");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
